// File: rtl/nibbler_pkg.sv
// Nibbler shared definitions.
// Default field widths and the fetch queue entry layout.
package nibbler_pkg;

  localparam int DEF_OPCODE_W  = 4;
  localparam int DEF_OPERAND_W = 4;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DEPTH     = 2;

  typedef struct packed {
    logic [DEF_OPCODE_W-1:0]  opcode;
    logic [DEF_OPERAND_W-1:0] operand;
    logic [DEF_ADDR_W-1:0]    pc;
  } fetch_entry_t;

  function automatic int entry_w(
    input int op_w,
    input int opd_w,
    input int a_w
  );
    return op_w + opd_w + a_w;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Nibbler prefetch FIFO.
// Holds {opcode, operand, pc} entries between fetch and decode.
module fetch_queue
  import nibbler_pkg::*;
#(
  parameter int W     = entry_w(DEF_OPCODE_W, DEF_OPERAND_W, DEF_ADDR_W),
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  // flush empties the queue ahead of any push or pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Nibbler instruction fetch stage.
// Single-outstanding memory port feeding a prefetch queue.
module fetch_unit
  import nibbler_pkg::*;
#(
  parameter int OPCODE_W  = DEF_OPCODE_W,
  parameter int OPERAND_W = DEF_OPERAND_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [OPCODE_W+OPERAND_W-1:0] mem_rdata,
  input  logic                          mem_rvalid,
  input  logic                          redirect,
  input  logic [ADDR_W-1:0]             redirect_addr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [OPCODE_W-1:0]           instruction,
  output logic [OPERAND_W-1:0]          operand,
  output logic [ADDR_W-1:0]             instr_pc
);

  localparam int EW = entry_w(OPCODE_W, OPERAND_W, ADDR_W);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              outstanding;
  logic              discard;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              resp;
  logic              push;
  logic              pop;

  assign mem_req  = !reset && !redirect && !outstanding && (count < FULL);
  assign mem_addr = reset ? '0 : pc;

  assign resp = mem_rvalid && outstanding;
  assign push = resp && !discard && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instruction = head[EW-1 -: OPCODE_W];
  assign operand     = head[ADDR_W +: OPERAND_W];
  assign instr_pc    = head[ADDR_W-1:0];

  fetch_queue #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({mem_rdata, req_pc}),
    .count (count),
    .head  (head)
  );

  // pc advance, request tracking and stale-response bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= redirect_addr;
      end else if (mem_req) begin
        pc     <= pc + 1'b1;
        req_pc <= pc;
      end
      if (mem_req) outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;
      if (redirect && outstanding && !mem_rvalid) discard <= 1'b1;
      else if (resp) discard <= 1'b0;
    end
  end

endmodule
